pipe_ctrl: RTL and testbench

Pipeline sequencing controller for the 5-stage RV32I core (IF/ID/EX/MEM/WB). Detects load-use hazards against the decode stage's register read requests, and freezes the front end while a multi-cycle EX operation (mul/div unit) runs. It redirects fetch on taken branches and parks the core on an external debug halt. It drives per-stage stall and bubble controls consumed by the pipeline registers and the PC register, and keeps a saturating stall-cycle counter.

---
 rtl/pipe_ctrl.sv | 116 +++++++++++
 tb/tb_pipe_ctrl.sv | 278 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/pipe_ctrl.sv
// Pipeline sequencing controller for the 5-stage RV32I core: load-use interlock,
// multi-cycle EX freeze, branch redirect, debug halt and a saturating stall counter.
module pipe_ctrl (
    input  logic        clk,
    input  logic        rst,
    input  logic        id_reg1re,
    input  logic [4:0]  id_reg1addr,
    input  logic        id_reg2re,
    input  logic [4:0]  id_reg2addr,
    input  logic [4:0]  ex_rd,
    input  logic        ex_regwe,
    input  logic        ex_isload,
    input  logic        ex_mdu_start,
    input  logic        ex_mdu_done,
    input  logic        ex_branch_taken,
    input  logic [31:0] ex_branch_target,
    input  logic        dbg_halt,
    input  logic        dbg_resume,
    output logic [5:0]  stall,
    output logic        flush_id,
    output logic        bubble_ex,
    output logic        bubble_mem,
    output logic        new_pc_valid,
    output logic [31:0] new_pc,
    output logic        halted,
    output logic [15:0] stall_cnt
);

    typedef enum logic [1:0] {
        RUN      = 2'd0,
        MDU_WAIT = 2'd1,
        HALT     = 2'd2
    } state_t;

    localparam logic [5:0] STALL_FRONT = 6'b000111;
    localparam logic [5:0] STALL_EX    = 6'b001111;

    state_t state, state_next;
    logic   halt_pend, halt_pend_next;
    logic   luh;

    // The load result is only available after MEM, so a consumer in ID must wait one slot.
    always_comb begin
        luh = ex_regwe && ex_isload && (ex_rd != 5'd0) &&
              ((id_reg1re && (id_reg1addr == ex_rd)) ||
               (id_reg2re && (id_reg2addr == ex_rd)));
    end

    always_comb begin
        // NOTE: every output gets a default first so no path leaves it unassigned (no latches).
        state_next     = state;
        halt_pend_next = halt_pend;
        stall          = '0;
        flush_id       = 1'b0;
        bubble_ex      = 1'b0;
        bubble_mem     = 1'b0;
        new_pc_valid   = 1'b0;
        new_pc         = '0;

        if (!rst) begin
            unique case (state)
                RUN: begin
                    if (ex_branch_taken) begin
                        new_pc_valid = 1'b1;
                        new_pc       = ex_branch_target;
                        flush_id     = 1'b1;
                        bubble_ex    = 1'b1;
                        if (dbg_halt) halt_pend_next = 1'b1;
                    end else if (ex_mdu_start && !ex_mdu_done) begin
                        state_next = MDU_WAIT;
                    end else if (luh) begin
                        stall     = STALL_FRONT;
                        bubble_ex = 1'b1;
                    end else if (dbg_halt || halt_pend) begin
                        state_next     = HALT;
                        halt_pend_next = 1'b0;
                        stall          = STALL_FRONT;
                        bubble_ex      = 1'b1;
                    end
                end
                MDU_WAIT: begin
                    if (dbg_halt) halt_pend_next = 1'b1;
                    if (ex_mdu_done) begin
                        state_next = RUN;
                    end else begin
                        stall      = STALL_EX;
                        bubble_mem = 1'b1;
                    end
                end
                HALT: begin
                    stall     = STALL_FRONT;
                    bubble_ex = 1'b1;
                    if (dbg_resume) state_next = RUN;
                end
                default: state_next = RUN;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        // NOTE: non-blocking assignments so all state samples pre-edge values together.
        if (rst) begin
            state     <= RUN;
            halt_pend <= 1'b0;
            halted    <= 1'b0;
            stall_cnt <= '0;
        end else begin
            state     <= state_next;
            halt_pend <= halt_pend_next;
            halted    <= (state_next == HALT);
            if (stall[0] && (stall_cnt != 16'hFFFF))
                stall_cnt <= stall_cnt + 16'd1;
        end
    end

endmodule

// File: tb/tb_pipe_ctrl.sv
// Directed testbench for pipe_ctrl: hazard, branch, MDU, halt, saturation and reset
// scenarios with hand-computed expected values.
module tb_pipe_ctrl;

    logic        clk = 1'b0;
    logic        rst;
    logic        id_reg1re, id_reg2re;
    logic [4:0]  id_reg1addr, id_reg2addr, ex_rd;
    logic        ex_regwe, ex_isload, ex_mdu_start, ex_mdu_done, ex_branch_taken;
    logic [31:0] ex_branch_target;
    logic        dbg_halt, dbg_resume;
    logic [5:0]  stall;
    logic        flush_id, bubble_ex, bubble_mem, new_pc_valid, halted;
    logic [31:0] new_pc;
    logic [15:0] stall_cnt;

    int n_checks = 0;
    int n_pass   = 0;

    always #5 clk = ~clk;

    pipe_ctrl dut (
        .clk              (clk),
        .rst              (rst),
        .id_reg1re        (id_reg1re),
        .id_reg1addr      (id_reg1addr),
        .id_reg2re        (id_reg2re),
        .id_reg2addr      (id_reg2addr),
        .ex_rd            (ex_rd),
        .ex_regwe         (ex_regwe),
        .ex_isload        (ex_isload),
        .ex_mdu_start     (ex_mdu_start),
        .ex_mdu_done      (ex_mdu_done),
        .ex_branch_taken  (ex_branch_taken),
        .ex_branch_target (ex_branch_target),
        .dbg_halt         (dbg_halt),
        .dbg_resume       (dbg_resume),
        .stall            (stall),
        .flush_id         (flush_id),
        .bubble_ex        (bubble_ex),
        .bubble_mem       (bubble_mem),
        .new_pc_valid     (new_pc_valid),
        .new_pc           (new_pc),
        .halted           (halted),
        .stall_cnt        (stall_cnt)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", tag, got, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_idle();
        id_reg1re        = 1'b0;
        id_reg1addr      = 5'd0;
        id_reg2re        = 1'b0;
        id_reg2addr      = 5'd0;
        ex_rd            = 5'd0;
        ex_regwe         = 1'b0;
        ex_isload        = 1'b0;
        ex_mdu_start     = 1'b0;
        ex_mdu_done      = 1'b0;
        ex_branch_taken  = 1'b0;
        ex_branch_target = 32'd0;
        dbg_halt         = 1'b0;
        dbg_resume       = 1'b0;
    endtask

    initial begin
        // Reset forces combinational outputs to zero even with a taken branch present.
        rst = 1'b1;
        set_idle();
        ex_branch_taken  = 1'b1;
        ex_branch_target = 32'h0000_0100;
        dbg_halt         = 1'b1;
        #1;
        check("rst_stall", stall, 6'b0);
        check("rst_npc_valid", new_pc_valid, 1'b0);
        check("rst_npc", new_pc, 32'h0);
        check("rst_flush", flush_id, 1'b0);
        tick();
        check("rst_halted", halted, 1'b0);
        check("rst_cnt", stall_cnt, 16'd0);

        rst = 1'b0;
        set_idle();
        #1;
        check("idle_stall", stall, 6'b0);
        tick();

        // Load-use on rs1.
        ex_isload = 1'b1; ex_regwe = 1'b1; ex_rd = 5'd5;
        id_reg1re = 1'b1; id_reg1addr = 5'd5;
        #1;
        check("luh1_stall", stall, 6'b000111);
        check("luh1_bubble_ex", bubble_ex, 1'b1);
        check("luh1_flush", flush_id, 1'b0);
        tick();
        check("luh1_cnt", stall_cnt, 16'd1);

        // Destination x0 never hazards.
        ex_rd = 5'd0;
        #1;
        check("luh_x0_stall", stall, 6'b0);
        tick();

        // Load-use on rs2.
        set_idle();
        ex_isload = 1'b1; ex_regwe = 1'b1; ex_rd = 5'd3;
        id_reg2re = 1'b1; id_reg2addr = 5'd3;
        #1;
        check("luh2_stall", stall, 6'b000111);
        tick();
        check("luh2_cnt", stall_cnt, 16'd2);

        // Matching address without read enable is not a hazard.
        id_reg2re = 1'b0; id_reg1re = 1'b0; id_reg1addr = 5'd3;
        #1;
        check("noread_stall", stall, 6'b0);
        tick();

        // Branch overrides hazard; concurrent halt request is deferred.
        id_reg1re = 1'b1;
        ex_branch_taken = 1'b1; ex_branch_target = 32'h0000_0100; dbg_halt = 1'b1;
        #1;
        check("br_npc_valid", new_pc_valid, 1'b1);
        check("br_npc", new_pc, 32'h0000_0100);
        check("br_flush", flush_id, 1'b1);
        check("br_bubble_ex", bubble_ex, 1'b1);
        check("br_stall", stall, 6'b0);
        tick();
        check("br_halted", halted, 1'b0);

        // Pending halt taken on the next plain RUN cycle.
        set_idle();
        #1;
        check("pend_stall", stall, 6'b000111);
        check("pend_bubble_ex", bubble_ex, 1'b1);
        check("pend_npc", new_pc, 32'h0);
        tick();
        check("pend_halted", halted, 1'b1);
        check("pend_cnt", stall_cnt, 16'd3);

        dbg_resume = 1'b1;
        #1;
        check("resume_stall", stall, 6'b000111);
        tick();
        check("resume_halted", halted, 1'b0);
        check("resume_cnt", stall_cnt, 16'd4);
        set_idle();
        #1;
        check("post_resume_stall", stall, 6'b0);
        tick();

        // MDU op: start, four wait cycles, done.
        ex_mdu_start = 1'b1;
        #1;
        check("mdu_start_stall", stall, 6'b0);
        tick();
        set_idle();
        for (int i = 0; i < 4; i++) begin
            #1;
            check("mdu_wait_stall", stall, 6'b001111);
            check("mdu_wait_bmem", bubble_mem, 1'b1);
            check("mdu_wait_bex", bubble_ex, 1'b0);
            tick();
        end
        ex_mdu_done = 1'b1;
        #1;
        check("mdu_done_stall", stall, 6'b0);
        check("mdu_done_bmem", bubble_mem, 1'b0);
        tick();
        set_idle();
        check("mdu_cnt", stall_cnt, 16'd8);

        // Start and done together is a single-cycle op.
        ex_mdu_start = 1'b1; ex_mdu_done = 1'b1;
        #1;
        check("mdu1_stall", stall, 6'b0);
        tick();
        set_idle();
        #1;
        check("mdu1_next_stall", stall, 6'b0);
        check("mdu1_next_bmem", bubble_mem, 1'b0);
        tick();

        // Halt pulse during MDU_WAIT is honoured after the op completes.
        ex_mdu_start = 1'b1;
        #1;
        tick();
        set_idle();
        dbg_halt = 1'b1;
        #1;
        check("mduh_w1_stall", stall, 6'b001111);
        tick();
        dbg_halt = 1'b0;
        #1;
        check("mduh_w2_stall", stall, 6'b001111);
        tick();
        ex_mdu_done = 1'b1;
        #1;
        check("mduh_done_stall", stall, 6'b0);
        check("mduh_done_halted", halted, 1'b0);
        tick();
        set_idle();
        #1;
        check("mduh_run_stall", stall, 6'b000111);
        check("mduh_run_bex", bubble_ex, 1'b1);
        tick();
        check("mduh_halted", halted, 1'b1);
        check("mduh_cnt", stall_cnt, 16'd11);

        // Long HALT saturates the counter.
        repeat (65540) tick();
        check("sat_cnt", stall_cnt, 16'hFFFF);
        check("sat_halted", halted, 1'b1);
        check("sat_stall", stall, 6'b000111);
        tick();
        check("sat_hold_cnt", stall_cnt, 16'hFFFF);

        // Reset while halted leaves no residue.
        rst = 1'b1;
        #1;
        check("rsth_stall", stall, 6'b0);
        check("rsth_bex", bubble_ex, 1'b0);
        tick();
        check("rsth_halted", halted, 1'b0);
        check("rsth_cnt", stall_cnt, 16'd0);
        rst = 1'b0;
        #1;
        check("rsth_run_stall", stall, 6'b0);
        tick();

        // Held halt across resume re-enters HALT after one RUN cycle.
        dbg_halt = 1'b1;
        #1;
        check("hold_enter_stall", stall, 6'b000111);
        tick();
        check("hold_halted1", halted, 1'b1);
        dbg_resume = 1'b1;
        tick();
        check("hold_resumed", halted, 1'b0);
        dbg_resume = 1'b0;
        #1;
        check("hold_run_stall", stall, 6'b000111);
        tick();
        check("hold_halted2", halted, 1'b1);

        // Reset mid MDU_WAIT.
        set_idle();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        ex_mdu_start = 1'b1;
        tick();
        set_idle();
        #1;
        check("rstm_wait_stall", stall, 6'b001111);
        rst = 1'b1;
        #1;
        check("rstm_rst_stall", stall, 6'b0);
        tick();
        rst = 1'b0;
        #1;
        check("rstm_after_stall", stall, 6'b0);
        check("rstm_after_bmem", bubble_mem, 1'b0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
